// File: rtl/nnacc_arb_pkg.sv
// Shared definitions for the accelerator load-port arbiter.
//   NUM_REQ / ID_W : requester count and id width
//   arb_state_t    : arbiter FSM states
//   DEF_MAX_BURST  : default beat limit per grant
package nnacc_arb_pkg;
  localparam int NUM_REQ       = 16;
  localparam int ID_W          = 4;
  localparam int DEF_MAX_BURST = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/decoder4_16.sv
// 4-to-16 one-hot decoder.
//   i_sel : binary index
//   o_dec : one-hot vector with bit i_sel set
module decoder4_16 (
  input  logic [3:0]  i_sel,
  output logic [15:0] o_dec
);
  assign o_dec = 16'h0001 << i_sel;
endmodule

// File: rtl/rr_pick16.sv
// Rotating-priority picker: returns the first set request scanning
// i_ptr+1, i_ptr+2, ... wrapping modulo 16, so i_ptr itself is checked last.
//   i_req    : request vector
//   i_ptr    : last winner
//   o_any    : at least one request set
//   o_win_id : index of the selected requester
module rr_pick16 import nnacc_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_any,
  output logic [ID_W-1:0]    o_win_id
);
  always_comb begin
    logic [ID_W-1:0] w_idx;
    o_any    = 1'b0;
    o_win_id = '0;
    w_idx    = '0;
    // Walk from the farthest offset to the nearest so the nearest set
    // request overwrites the rest; offset 16 wraps to i_ptr itself.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = i_ptr + ID_W'(k);
      if (i_req[w_idx]) begin
        o_any    = 1'b1;
        o_win_id = w_idx;
      end
    end
  end
endmodule

// File: rtl/rr_arb16_ctrl.sv
// Burst-locked round-robin arbiter for 16 requesters sharing one resource.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : allow new grants (running burst always completes)
//   req, last   : per-requester request level and last-beat flag
//   res_ready   : resource accepts a beat this cycle
//   gnt_valid   : grant active; gnt_id / gnt give the winner (gnt zero when idle)
//   beat        : combinational transfer pulse
//   burst_done, timeout, abort : one-cycle release pulses, asserted in the REL cycle
module rr_arb16_ctrl import nnacc_arb_pkg::*; #(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  input  logic [15:0] last,
  input  logic        res_ready,
  output logic        gnt_valid,
  output logic [3:0]  gnt_id,
  output logic [15:0] gnt,
  output logic        beat,
  output logic        burst_done,
  output logic        timeout,
  output logic        abort
);
  arb_state_t       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]  r_gnt_id, w_gnt_id_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             r_to, w_to_nxt;
  logic             r_abort, w_abort_nxt;

  logic               w_any;
  logic [ID_W-1:0]    w_win_id;
  logic [NUM_REQ-1:0] w_dec;
  logic               w_req_cur, w_last_cur, w_beat, w_cnt_max;

  rr_pick16 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_win_id (w_win_id)
  );

  decoder4_16 u_dec (
    .i_sel (r_gnt_id),
    .o_dec (w_dec)
  );

  assign w_req_cur  = req[r_gnt_id];
  assign w_last_cur = last[r_gnt_id];
  assign w_beat     = r_gnt_valid & w_req_cur & res_ready;
  // Counter holds beats already taken; the beat seen while it equals
  // MAX_BURST-1 is the final permitted one.
  assign w_cnt_max  = (r_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_id_nxt    = r_gnt_id;
    w_cnt_nxt       = r_cnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_done_nxt      = 1'b0;
    w_to_nxt        = 1'b0;
    w_abort_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_any) begin
          w_gnt_id_nxt    = w_win_id;
          w_gnt_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (!w_req_cur) begin
          w_abort_nxt     = 1'b1;
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = REL;
        end else if (w_beat) begin
          if (w_last_cur) begin
            // last wins over the beat limit: a normal end, not a timeout
            w_done_nxt      = 1'b1;
            w_gnt_valid_nxt = 1'b0;
            w_state_nxt     = REL;
          end else if (w_cnt_max) begin
            w_done_nxt      = 1'b1;
            w_to_nxt        = 1'b1;
            w_gnt_valid_nxt = 1'b0;
            w_state_nxt     = REL;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      REL: begin
        // Finished requester becomes lowest priority for the next search.
        w_ptr_nxt   = r_gnt_id;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_gnt_id    <= '0;
      r_cnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_to        <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_done      <= w_done_nxt;
      r_to        <= w_to_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_id     = r_gnt_id;
  assign gnt        = w_dec & {NUM_REQ{r_gnt_valid}};
  assign beat       = w_beat;
  assign burst_done = r_done;
  assign timeout    = r_to;
  assign abort      = r_abort;
endmodule
